// File: rtl/param_counter_top.sv
// rtl/param_counter_top.sv - prescaled modulo up/down counter with load and terminal-count pulse
// Optional COUNTER_SAT_EN: counter saturates at its limits instead of wrapping.
module param_counter_top #(
    parameter int WIDTH     = 4,
    parameter int MODULO    = 16,
    parameter int DIV_RATIO = 4
) (
    input  logic             clk,
    input  logic             rs,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             tick_o
);

    localparam int               PW       = (DIV_RATIO > 2) ? $clog2(DIV_RATIO) : 1;
    localparam logic [PW-1:0]    PRE_LAST = PW'(DIV_RATIO - 1);
    localparam logic [WIDTH-1:0] Q_MAX    = WIDTH'(MODULO - 1);

    logic [PW-1:0]    r_presc;
    logic             r_tick;
    logic [WIDTH-1:0] r_q;
    logic             r_tc;

    logic             w_presc_last;
    logic             w_load_ok;
    logic             w_at_max;
    logic             w_at_zero;
    logic [WIDTH-1:0] w_q_next;
    logic             w_tc_next;

    assign w_presc_last = (r_presc == PRE_LAST);
    // Compare in 32 bits so MODULO == 2**WIDTH never overflows the load check.
    assign w_load_ok    = (32'(d) < 32'(MODULO));
    assign w_at_max     = (r_q == Q_MAX);
    assign w_at_zero    = (r_q == '0);

    always_comb begin
        w_q_next  = r_q;
        w_tc_next = 1'b0;
        if (load) begin
            w_q_next = w_load_ok ? d : Q_MAX;
        end else if (r_tick && en) begin
            if (up) begin
                if (w_at_max) begin
`ifdef COUNTER_SAT_EN
                    w_q_next  = r_q;
`else
                    w_q_next  = '0;
`endif
                    w_tc_next = 1'b1;
                end else begin
                    w_q_next = r_q + WIDTH'(1);
                end
            end else begin
                if (w_at_zero) begin
`ifdef COUNTER_SAT_EN
                    w_q_next  = r_q;
`else
                    w_q_next  = Q_MAX;
`endif
                    w_tc_next = 1'b1;
                end else begin
                    w_q_next = r_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rs) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
            r_q     <= '0;
            r_tc    <= 1'b0;
        end else begin
            r_presc <= w_presc_last ? '0 : r_presc + PW'(1);
            r_tick  <= w_presc_last;
            r_q     <= w_q_next;
            r_tc    <= w_tc_next;
        end
    end

    assign q      = r_q;
    assign tc     = r_tc;
    assign tick_o = r_tick;

endmodule
